// File: rtl/rgmii_tx_fmt_if.sv
// Byte stream from the MAC into the RGMII transmit formatter.
// The MAC is the master. The formatter is the slave and drives tready.
interface rgmii_tx_fmt_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rgmii_tx_fmt.sv
// RGMII transmit formatter: wraps MAC frames in preamble/SFD, enforces the IFG,
// and presents the two DDR nibbles and the TX_EN / TX_EN^TX_ER control pair per cycle.
module rgmii_tx_fmt #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_LEN      = 12
) (
    input  logic              phy_clk,
    input  logic              phy_rst_n,
    rgmii_tx_fmt_if.slave     s,
    output logic [3:0]        txd_d1,
    output logic [3:0]        txd_d2,
    output logic              txctl_d1,
    output logic              txctl_d2,
    output logic              tx_busy,
    output logic              underflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_ABORT,
        ST_IFG
    } state_e;

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] PRE_TERM = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] IFG_TERM = CNT_W'(IFG_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             en_q, en_d;
    logic             ctl2_q;
    logic             er_d;
    logic             busy_q;
    logic             uf_q, uf_d;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge phy_clk or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            en_q    <= 1'b0;
            ctl2_q  <= 1'b0;
            busy_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            en_q    <= en_d;
            ctl2_q  <= en_d ^ er_d;
            busy_q  <= (state_d != ST_IDLE);
            uf_q    <= uf_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE:  if (s.tvalid) state_d = ST_PRE;
            ST_PRE: begin
                if (cnt_q == PRE_TERM) state_d = ST_SFD;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_SFD:   state_d = ST_DATA;
            ST_DATA: begin
                if (!s.tvalid)     state_d = ST_ABORT;
                else if (s.tlast)  state_d = ST_IFG;
            end
            ST_ABORT: if (s.tvalid && s.tlast) state_d = ST_IFG;
            ST_IFG: begin
                if (cnt_q == IFG_TERM) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
        // Each state counts from zero, so the counter clears on every transition.
        if (state_d != state_q) cnt_d = '0;
    end

    // TX_EN=0 leaves byte and error at zero, which keeps the whole wire quiet between frames.
    always_comb begin
        byte_d = '0;
        en_d   = 1'b0;
        er_d   = 1'b0;
        uf_d   = 1'b0;
        unique case (state_q)
            ST_PRE: begin
                en_d   = 1'b1;
                byte_d = 8'h55;
            end
            ST_SFD: begin
                en_d   = 1'b1;
                byte_d = 8'hD5;
            end
            ST_DATA: begin
                en_d = 1'b1;
                if (s.tvalid) begin
                    byte_d = s.tdata;
                    er_d   = s.tuser;
                end else begin
                    er_d = 1'b1;
                    uf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign s.tready  = (state_q == ST_DATA) || (state_q == ST_ABORT);
    assign txd_d1    = byte_q[3:0];
    assign txd_d2    = byte_q[7:4];
    assign txctl_d1  = en_q;
    assign txctl_d2  = ctl2_q;
    assign tx_busy   = busy_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_rgmii_tx_fmt.sv
// Directed bench for rgmii_tx_fmt: per-cycle vector tables plus hand-written
// back-to-back, mid-frame reset and short-parameter sequences.
module tb_rgmii_tx_fmt;

    logic phy_clk = 1'b0;
    logic phy_rst_n;
    always #4 phy_clk = ~phy_clk;

    rgmii_tx_fmt_if s_a ();
    rgmii_tx_fmt_if s_b ();

    logic [3:0] a_txd_d1, a_txd_d2, b_txd_d1, b_txd_d2;
    logic       a_ctl1, a_ctl2, a_busy, a_uf;
    logic       b_ctl1, b_ctl2, b_busy, b_uf;

    rgmii_tx_fmt u_dut_a (
        .phy_clk   (phy_clk),
        .phy_rst_n (phy_rst_n),
        .s         (s_a),
        .txd_d1    (a_txd_d1),
        .txd_d2    (a_txd_d2),
        .txctl_d1  (a_ctl1),
        .txctl_d2  (a_ctl2),
        .tx_busy   (a_busy),
        .underflow (a_uf)
    );

    rgmii_tx_fmt #(.PREAMBLE_LEN(1), .IFG_LEN(1)) u_dut_b (
        .phy_clk   (phy_clk),
        .phy_rst_n (phy_rst_n),
        .s         (s_b),
        .txd_d1    (b_txd_d1),
        .txd_d2    (b_txd_d2),
        .txctl_d1  (b_ctl1),
        .txctl_d2  (b_ctl2),
        .tx_busy   (b_busy),
        .underflow (b_uf)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       en;
        logic       er;
        logic [7:0] wbyte;
        logic       rdy;
        logic       busy;
        logic       uf;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic [7:0] d, input logic l, input logic u,
                        input logic en, input logic er, input logic [7:0] b,
                        input logic rdy, input logic busy, input logic uf);
        vec_t t;
        t.valid = v; t.data = d; t.last = l; t.user = u;
        t.en = en; t.er = er; t.wbyte = b; t.rdy = rdy; t.busy = busy; t.uf = uf;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic u);
        s_a.tvalid = v; s_a.tdata = d; s_a.tlast = l; s_a.tuser = u;
        s_b.tvalid = v; s_b.tdata = d; s_b.tlast = l; s_b.tuser = u;
    endtask

    // Observed word: {txd_d2, txd_d1, txctl_d1, txctl_d2, tx_busy, underflow, s_tready}
    function automatic logic [12:0] obs(input bit sel);
        if (sel) return {b_txd_d2, b_txd_d1, b_ctl1, b_ctl2, b_busy, b_uf, s_b.tready};
        return {a_txd_d2, a_txd_d1, a_ctl1, a_ctl2, a_busy, a_uf, s_a.tready};
    endfunction

    function automatic logic [12:0] expv(input vec_t t);
        logic [7:0] b;
        b = t.en ? t.wbyte : 8'h00;
        return {b[7:4], b[3:0], t.en, t.en ^ t.er, t.busy, t.uf, t.rdy};
    endfunction

    // Each row: drive inputs, take one edge, compare the post-edge outputs.
    task automatic apply(input string tag, input bit sel);
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].user);
            @(posedge phy_clk); #1;
            check($sformatf("%s[%0d]", tag, i), 32'(obs(sel)), 32'(expv(vecs[i])));
        end
        vecs.delete();
    endtask

    // IDLE->PRE row, seven preamble rows, SFD row (default parameters).
    task automatic push_preamble(input logic [7:0] d);
        push(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 7; p++)
            push(1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
        push(1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0, 8'hD5, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic push_ifg12();
        for (int j = 0; j < 12; j++)
            push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, (j < 11), 1'b0);
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_frame4(input int err_idx);
        logic [7:0] fb [4];
        fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; fb[3] = 8'hDD;
        push_preamble(fb[0]);
        for (int k = 0; k < 4; k++)
            push(1'b1, fb[k], (k == 3), (k == err_idx), 1'b1, (k == err_idx), fb[k],
                 (k < 3), 1'b1, 1'b0);
        push_ifg12();
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        phy_rst_n = 1'b0;
        repeat (2) @(posedge phy_clk);
        @(negedge phy_clk) phy_rst_n = 1'b1;
        @(posedge phy_clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fb [4];
        int         idx, gap;
        bit         hs, seen_dd, done, found;

        fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; fb[3] = 8'hDD;

        // Reset state
        phy_rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #10;
        check("reset_a", 32'(obs(1'b0)), 32'h0);
        check("reset_b", 32'(obs(1'b1)), 32'h0);
        @(negedge phy_clk) phy_rst_n = 1'b1;
        @(posedge phy_clk); #1;
        check("post_release_a", 32'(obs(1'b0)), 32'h0);

        // Plain 4-byte frame
        push_frame4(-1);
        apply("frame", 1'b0);

        // Same frame with an errored second byte
        push_frame4(1);
        apply("err_frame", 1'b0);

        // Underflow after byte 2 of 5, then drain in ABORT
        push_preamble(8'h11);
        push(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0);
        push(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0);
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        push(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        push(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        push(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        push_ifg12();
        apply("underflow", 1'b0);

        // Back-to-back frames with tvalid held high: count idle cycles between DD and next 55
        idx = 0; gap = 0; seen_dd = 1'b0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            drive(1'b1, fb[idx], (idx == 3), 1'b0);
            hs = s_a.tready;
            @(posedge phy_clk); #1;
            if (hs) idx = (idx == 3) ? 0 : idx + 1;
            if (a_ctl1 && {a_txd_d2, a_txd_d1} == 8'hDD) begin
                seen_dd = 1'b1;
                gap     = 0;
            end else if (seen_dd && !a_ctl1) begin
                gap++;
            end else if (seen_dd && a_ctl1) begin
                done = 1'b1;
                check("b2b_first_byte", 32'({a_txd_d2, a_txd_d1}), 32'h55);
            end
        end
        check("b2b_done", 32'(done), 32'h1);
        check("b2b_gap", 32'(gap), 32'd13);

        // Reset asserted while the third data byte is on the wire
        do_reset();
        idx = 0; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            drive(1'b1, fb[idx], (idx == 3), 1'b0);
            hs = s_a.tready;
            @(posedge phy_clk); #1;
            if (hs && idx < 3) idx++;
            if (a_ctl1 && {a_txd_d2, a_txd_d1} == 8'hCC) found = 1'b1;
        end
        check("rst_reach_cc", 32'(found), 32'h1);
        #1 phy_rst_n = 1'b0;
        #1;
        check("rst_async_a", 32'(obs(1'b0)), 32'h0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge phy_clk);
        @(negedge phy_clk) phy_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge phy_clk); #1;
            check($sformatf("rst_no_tail[%0d]", c), 32'(obs(1'b0)), 32'h0);
        end

        // PREAMBLE_LEN=1, IFG_LEN=1, one-byte frame on the second instance
        do_reset();
        push(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        push(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
        push(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'hD5, 1'b1, 1'b1, 1'b0);
        push(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        apply("short_params", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
